// File: rtl/encode_pkg.sv
// Shared types and constants for the (2,1,2) convolutional encoder frame sequencer.
package encode_pkg;

  // Sequencer states: IDLE -> CLEAR -> DATA -> TAIL -> IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DATA  = 2'd2,
    TAIL  = 2'd3
  } state_t;

  localparam int TAIL_LEN = 2;  // zero bits flushed to terminate the trellis
  localparam int CODE_W   = 2;  // code symbol width {g1,g2}
  localparam int K        = 3;  // constraint length

  // Limit a requested bit count to the frame capacity.
  function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] max_len);
    clamp_len = (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/frame_shifter.sv
// Message shift register with a down-counter of bits still to be sent.
// Loads a frame LSB-first; each shift exposes the next bit on bit_sig.
module frame_shifter
  import encode_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_sig,
  input  logic               reset_sig,
  input  logic               load_sig,
  input  logic               shift_sig,
  input  logic [MAX_LEN-1:0] frame_sig,
  input  logic [LEN_W-1:0]   len_sig,
  output logic               bit_sig,
  output logic               last_bit_sig,
  output logic               empty_sig
);

  logic [MAX_LEN-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;

  // Next shift/count: load wins; shifting stops once the count is exhausted.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_sig) begin
      shift_d = frame_sig;
      cnt_d   = LEN_W'(clamp_len(32'(len_sig), 32'(MAX_LEN)));
    end else if (shift_sig && (cnt_q != '0)) begin
      shift_d = shift_q >> 1;
      cnt_d   = cnt_q - LEN_W'(1);
    end
  end

  // Register state, cleared by async reset.
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_sig      = shift_q[0];
  assign last_bit_sig = (cnt_q == LEN_W'(1));
  assign empty_sig    = (cnt_q == '0);

endmodule

// File: rtl/encode_frame_ctrl.sv
// Frame sequencer for the (2,1,2) convolutional encoder.
// Accepts a message frame, clears the encoder, serialises bits LSB-first,
// and frames the encoder output as a code stream with sof/eof.
// Build option: define ENCODE_TAIL_EN to append a 2-bit zero tail that
// returns the encoder to state 00 (eof moves to the last tail symbol).
//
// state | meaning
// IDLE  | waiting for a frame, in_ready high
// CLEAR | encoder held in sync clear for one cycle
// DATA  | one message bit per cycle into the encoder
// TAIL  | zero flush bits (ENCODE_TAIL_EN only)
module encode_frame_ctrl
  import encode_pkg::*;
#(
  parameter  int MAX_LEN = 64,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_sig,
  input  logic               reset_sig,
  input  logic               in_valid_sig,
  output logic               in_ready_sig,
  input  logic [MAX_LEN-1:0] frame_sig,
  input  logic [LEN_W-1:0]   len_sig,
  output logic               enc_reset_sig,
  output logic               enc_q_sig,
  input  logic [CODE_W-1:0]  enc_code_sig,
  output logic [CODE_W-1:0]  code_sig,
  output logic               code_valid_sig,
  output logic               code_sof_sig,
  output logic               code_eof_sig,
  output logic               busy_sig,
  output logic               err_sig
);

`ifdef ENCODE_TAIL_EN
  localparam logic TAIL_EN = 1'b1;
  localparam int   TL_W    = 2;
  logic [TL_W-1:0] tail_left_q, tail_left_d;
`else
  localparam logic TAIL_EN = 1'b0;
`endif

  state_t state_q, state_d;
  logic   enc_reset_q, enc_reset_d;
  logic   enc_q_q, enc_q_d;
  logic   in_ready_q, in_ready_d;
  logic   err_q, err_d;
  // act/sof/eof flags travel with the bit on enc_q; code_* are them one cycle later
  logic   act_q, act_d;
  logic   sof_f_q, sof_f_d;
  logic   eof_f_q, eof_f_d;
  logic   code_valid_q, code_sof_q, code_eof_q;

  logic   load, shift;
  logic   sh_bit, sh_last, sh_empty;

  frame_shifter #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_shifter (
    .clk_sig     (clk_sig),
    .reset_sig   (reset_sig),
    .load_sig    (load),
    .shift_sig   (shift),
    .frame_sig   (frame_sig),
    .len_sig     (len_sig),
    .bit_sig     (sh_bit),
    .last_bit_sig(sh_last),
    .empty_sig   (sh_empty)
  );

  // Next state and next values of all registered outputs.
  always_comb begin
    state_d     = state_q;
    enc_reset_d = enc_reset_q;
    enc_q_d     = 1'b0;
    err_d       = 1'b0;
    act_d       = 1'b0;
    sof_f_d     = 1'b0;
    eof_f_d     = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
`ifdef ENCODE_TAIL_EN
    tail_left_d = tail_left_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid_sig && in_ready_q) begin
          if (len_sig == '0) begin
            err_d = 1'b1;
          end else begin
            load        = 1'b1;
            enc_reset_d = 1'b0;
            state_d     = CLEAR;
          end
        end
      end
      CLEAR: begin
        // first bit goes out as the encoder leaves clear
        state_d     = DATA;
        enc_reset_d = 1'b1;
        enc_q_d     = sh_bit;
        shift       = 1'b1;
        act_d       = 1'b1;
        sof_f_d     = 1'b1;
        eof_f_d     = sh_last & ~TAIL_EN;
      end
      DATA: begin
        if (!sh_empty) begin
          enc_q_d = sh_bit;
          shift   = 1'b1;
          act_d   = 1'b1;
          eof_f_d = sh_last & ~TAIL_EN;
        end else begin
`ifdef ENCODE_TAIL_EN
          state_d     = TAIL;
          act_d       = 1'b1;
          eof_f_d     = (TAIL_LEN == 1);
          tail_left_d = TL_W'(TAIL_LEN - 1);
`else
          state_d = IDLE;
`endif
        end
      end
      TAIL: begin
`ifdef ENCODE_TAIL_EN
        if (tail_left_q != '0) begin
          act_d       = 1'b1;
          eof_f_d     = (tail_left_q == TL_W'(1));
          tail_left_d = tail_left_q - TL_W'(1);
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // FSM state and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      state_q      <= IDLE;
      enc_reset_q  <= 1'b0;
      enc_q_q      <= 1'b0;
      in_ready_q   <= 1'b0;
      err_q        <= 1'b0;
      act_q        <= 1'b0;
      sof_f_q      <= 1'b0;
      eof_f_q      <= 1'b0;
      code_valid_q <= 1'b0;
      code_sof_q   <= 1'b0;
      code_eof_q   <= 1'b0;
`ifdef ENCODE_TAIL_EN
      tail_left_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      enc_reset_q  <= enc_reset_d;
      enc_q_q      <= enc_q_d;
      in_ready_q   <= in_ready_d;
      err_q        <= err_d;
      act_q        <= act_d;
      sof_f_q      <= sof_f_d;
      eof_f_q      <= eof_f_d;
      code_valid_q <= act_q;
      code_sof_q   <= sof_f_q;
      code_eof_q   <= eof_f_q;
`ifdef ENCODE_TAIL_EN
      tail_left_q  <= tail_left_d;
`endif
    end
  end

  assign in_ready_sig   = in_ready_q;
  assign enc_reset_sig  = enc_reset_q;
  assign enc_q_sig      = enc_q_q;
  assign err_sig        = err_q;
  assign busy_sig       = (state_q != IDLE);
  assign code_valid_sig = code_valid_q;
  assign code_sof_sig   = code_sof_q;
  assign code_eof_sig   = code_eof_q;
  // encoder output is only meaningful with valid; held at 0 otherwise (incl. reset)
  assign code_sig       = code_valid_q ? enc_code_sig : '0;

endmodule

// File: tb/tb_encode_frame_ctrl.sv
module tb_encode_frame_ctrl;
  import encode_pkg::*;

  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;
`ifdef ENCODE_TAIL_EN
  localparam bit TAIL_ON = 1'b1;
`else
  localparam bit TAIL_ON = 1'b0;
`endif
  localparam int NTAIL = TAIL_ON ? TAIL_LEN : 0;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic [MAX_LEN-1:0] frame = '0;
  logic [LEN_W-1:0]   len = '0;
  logic               in_ready, enc_reset, enc_q;
  logic [1:0]         enc_code = 2'b00;
  logic [1:0]         code;
  logic               code_valid, sof, eof, busy, err;

  always #5 clk = ~clk;

  encode_frame_ctrl #(.MAX_LEN(MAX_LEN)) dut (
    .clk_sig       (clk),
    .reset_sig     (rst_n),
    .in_valid_sig  (in_valid),
    .in_ready_sig  (in_ready),
    .frame_sig     (frame),
    .len_sig       (len),
    .enc_reset_sig (enc_reset),
    .enc_q_sig     (enc_q),
    .enc_code_sig  (enc_code),
    .code_sig      (code),
    .code_valid_sig(code_valid),
    .code_sof_sig  (sof),
    .code_eof_sig  (eof),
    .busy_sig      (busy),
    .err_sig       (err)
  );

  // Stand-in (2,1,2) encoder, g1=111 g2=101, registered output, sync active-low clear.
  logic [1:0] enc_st = 2'b00;
  always @(posedge clk) begin
    if (!enc_reset) begin
      enc_st   <= 2'b00;
      enc_code <= 2'b00;
    end else begin
      enc_code <= {enc_q ^ enc_st[0] ^ enc_st[1], enc_q ^ enc_st[1]};
      enc_st   <= {enc_st[0], enc_q};
    end
  end

  // Inputs as seen by each rising edge; cyc = number of edges so far.
  int                 cyc = 0;
  logic               s_valid = 1'b0;
  logic [MAX_LEN-1:0] s_frame = '0;
  logic [LEN_W-1:0]   s_len = '0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    s_valid <= in_valid;
    s_frame <= frame;
    s_len   <= len;
  end

  typedef struct {
    int       at;
    logic [1:0] code;
    bit       sof;
    bit       eof;
  } sym_t;

  sym_t exp_q[$];
  sym_t mk[$];

  int   n_vec = 0, n_fail = 0;
  bit   m_rdy = 1'b0;
  int   busy_end = -1;
  int   acc_count = 0, last_acc = -1;
  int   dut_sof_cyc = -1, n_valid_seen = 0, err_seen = 0;
  logic [1:0] dut_sof_code = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Expected code stream of one frame from the convolution rule:
  // u = data bits LSB-first then NTAIL zeros; c_i = {u_i^u_i-1^u_i-2, u_i^u_i-2}.
  function automatic void make_syms(input logic [MAX_LEN-1:0] f, input int l, input int t0);
    int n;
    bit u[MAX_LEN + TAIL_LEN];
    bit p1, p2;
    sym_t s;
    mk.delete();
    n = l + NTAIL;
    for (int i = 0; i < n; i++) u[i] = (i < l) ? f[i] : 1'b0;
    for (int i = 0; i < n; i++) begin
      p1     = (i >= 1) ? u[i-1] : 1'b0;
      p2     = (i >= 2) ? u[i-2] : 1'b0;
      s.at   = t0 + i;
      s.code = {u[i] ^ p1 ^ p2, u[i] ^ p2};
      s.sof  = (i == 0);
      s.eof  = (i == n - 1);
      mk.push_back(s);
    end
  endfunction

  // Reference model and per-cycle comparison, evaluated mid-cycle.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_rdy    = 1'b0;
      busy_end = -1;
      exp_q.delete();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_outs", {code_valid, sof, eof, code, enc_reset, enc_q}, 0);
    end else begin
      bit   acc, e_err, e_valid;
      int   l;
      acc   = s_valid && m_rdy;
      e_err = 1'b0;
      if (acc) begin
        acc_count++;
        last_acc = cyc;
        if (s_len == 0) begin
          e_err = 1'b1;
        end else begin
          l = (s_len > MAX_LEN) ? MAX_LEN : int'(s_len);
          // accept at edge a: first symbol visible after edge a+2, captured at a+3
          make_syms(s_frame, l, cyc + 2);
          foreach (mk[i]) exp_q.push_back(mk[i]);
          busy_end = cyc + l + NTAIL;
        end
      end
      m_rdy   = !(cyc <= busy_end);
      e_valid = (exp_q.size() > 0) && (exp_q[0].at == cyc);
      chk("busy", busy, (cyc <= busy_end));
      chk("in_ready", in_ready, m_rdy);
      chk("err", err, e_err);
      chk("code_valid", code_valid, e_valid);
      if (e_valid) begin
        chk("code", code, exp_q[0].code);
        chk("sof", sof, exp_q[0].sof);
        chk("eof", eof, exp_q[0].eof);
        void'(exp_q.pop_front());
      end
      if (code_valid) n_valid_seen++;
      if (code_valid && sof) begin
        dut_sof_cyc  = cyc;
        dut_sof_code = code;
      end
      if (err) err_seen++;
    end
  end

  // Offer a frame and hold it until the model says it was taken.
  task automatic send(input logic [MAX_LEN-1:0] f, input int l);
    int start, w;
    frame    = f;
    len      = LEN_W'(l);
    in_valid = 1'b1;
    start    = acc_count;
    w        = 0;
    while (acc_count == start && w < 300) begin
      @(negedge clk); #1;
      w++;
    end
    if (acc_count == start) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 300 cycles");
    end
    in_valid = 1'b0;
    frame    = {$urandom, $urandom};
    len      = LEN_W'($urandom_range(0, 127));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int a1, a2, v0, e0;
    logic [1:0] lit [6];
    logic [MAX_LEN-1:0] ones;
    lit  = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11};
    ones = '1;

    // model pins against hand-worked trellis values
    make_syms(MAX_LEN'(4'b1011), 4, 0);
    chk("model_len_1011", mk.size(), 4 + NTAIL);
    foreach (mk[i]) chk("model_code_1011", mk[i].code, lit[i]);
    chk("model_eof_1011", mk[mk.size()-1].eof, 1);
    make_syms(ones, MAX_LEN, 0);
    chk("model_ones_0", mk[0].code, 2'b11);
    chk("model_ones_1", mk[1].code, 2'b01);
    chk("model_ones_2", mk[2].code, 2'b10);
    chk("model_ones_last", mk[mk.size()-1].code, TAIL_ON ? 2'b11 : 2'b10);

    idle(3);
    rst_n = 1'b1;
    idle(2);

    // basic frame 1011, len 4
    v0 = n_valid_seen;
    send(MAX_LEN'(4'b1011), 4);
    a1 = last_acc;
    idle(12);
    chk("first_symbol_latency", dut_sof_cyc - a1, 2);
    chk("symbols_1011", n_valid_seen - v0, 4 + NTAIL);

    // zero length: discarded with an error pulse
    v0 = n_valid_seen;
    e0 = err_seen;
    send(MAX_LEN'(4'b1111), 0);
    idle(6);
    chk("len0_err_pulses", err_seen - e0, 1);
    chk("len0_symbols", n_valid_seen - v0, 0);

    // oversize length clamps to MAX_LEN
    v0 = n_valid_seen;
    send(ones, MAX_LEN + 5);
    idle(MAX_LEN + 8);
    chk("clamped_symbols", n_valid_seen - v0, MAX_LEN + NTAIL);

    // back-to-back: second offer held while busy
    send(MAX_LEN'(4'b1011), 4);
    a1 = last_acc;
    send(MAX_LEN'(4'b0001), 4);
    a2 = last_acc;
    chk("b2b_period", a2 - a1, TAIL_ON ? 8 : 6);
    idle(12);
    chk("b2b_second_sof_code", dut_sof_code, 2'b11);

    // reset mid-DATA aborts the frame
    send(ones, 10);
    idle(4);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {in_ready, busy, err, code_valid, sof, eof, code, enc_reset, enc_q}, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    v0 = n_valid_seen;
    send(MAX_LEN'(4'b1011), 4);
    idle(12);
    chk("post_rst_sof_code", dut_sof_code, 2'b11);
    chk("post_rst_symbols", n_valid_seen - v0, 4 + NTAIL);

    // randomized frames, lengths and gaps
    for (int k = 0; k < 40; k++) begin
      int r, l;
      r = $urandom_range(0, 9);
      if (r == 0)      l = 0;
      else if (r == 1) l = 1;
      else if (r == 2) l = MAX_LEN;
      else if (r == 3) l = $urandom_range(MAX_LEN + 1, 127);
      else             l = $urandom_range(1, 20);
      send({$urandom, $urandom}, l);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 5));
    end
    idle(MAX_LEN + 10);
    chk("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
